// File: rtl/rfnoc_block_pulse_shaping_filter_pkg.sv
// rtl/rfnoc_block_pulse_shaping_filter_pkg.sv - register map, types and arithmetic helpers for the pulse-shaping FIR
// Contents: register address constants, coef_t, sample_t, default_coef(), reg_coef_addr(), round_sat().
// Optional macro PULSE_SHAPING_SAT_EN: defined -> round_sat() saturates to int16, undefined -> wraps.
package rfnoc_block_pulse_shaping_filter_pkg;

    localparam logic [19:0] REG_USER_ADDR     = 20'h00000;
    localparam logic [19:0] REG_NUM_TAPS_ADDR = 20'h00008;
    localparam logic [19:0] REG_CLEAR_ADDR    = 20'h0000C;
    localparam logic [19:0] REG_COEF_BASE     = 20'h00100;

    localparam int PSF_COEF_W = 16;

`ifdef PULSE_SHAPING_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef logic signed [PSF_COEF_W-1:0] coef_t;

    // I occupies the upper half of the 32-bit item, Q the lower half.
    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } sample_t;

    // Pass-through: unity (Q1.15 max) on tap 0, all other taps zero.
    function automatic coef_t default_coef(input int k);
        coef_t c;
        c = '0;
        if (k == 0) begin
            c = 16'sh7FFF;
        end
        return c;
    endfunction

    function automatic logic [19:0] reg_coef_addr(input int k);
        return REG_COEF_BASE + 20'(4 * k);
    endfunction

    // Round half up from Q.15 then either clamp or keep the low 16 bits.
    function automatic logic signed [15:0] round_sat(input logic signed [63:0] acc);
        logic signed [63:0] r;
        r = (acc + 64'sd16384) >>> 15;
`ifdef PULSE_SHAPING_SAT_EN
        if (r > 64'sd32767) begin
            r = 64'sd32767;
        end else if (r < -64'sd32768) begin
            r = -64'sd32768;
        end
`endif
        return r[15:0];
    endfunction

endpackage

// File: rtl/psf_fir_mac.sv
// rtl/psf_fir_mac.sv - single-component FIR delay line and multiply-accumulate with rounding
// Ports: clk/rst (sync active-high), shift_en (accept a sample), clear (zero the delay line),
//        x_in (new sample), coefs (tap weights), y_out (registered filtered sample).
// Output behaviour depends on PULSE_SHAPING_SAT_EN through round_sat().
module psf_fir_mac
    import rfnoc_block_pulse_shaping_filter_pkg::*;
#(
    parameter int NUM_TAPS = 11,
    parameter int COEF_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en,
    input  logic                     clear,
    input  logic signed [15:0]       x_in,
    input  logic signed [COEF_W-1:0] coefs [NUM_TAPS],
    output logic signed [15:0]       y_out
);

    localparam int PROD_W = COEF_W + 16;
    localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);

    logic signed [15:0]       dly     [NUM_TAPS];
    logic signed [15:0]       dly_nxt [NUM_TAPS];
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    // The MAC works on the post-shift line so the accepted sample is already x[0]
    // when the result is registered, giving one cycle of latency.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            dly_nxt[k] = clear ? 16'sd0 : dly[k];
        end
        if (shift_en) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) begin
                dly_nxt[k] = clear ? 16'sd0 : dly[k-1];
            end
            dly_nxt[0] = x_in;
        end

        prod = '0;
        acc  = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod = PROD_W'(coefs[k]) * PROD_W'(dly_nxt[k]);
            acc  = acc + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                dly[k] <= '0;
            end
            y_out <= '0;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                dly[k] <= dly_nxt[k];
            end
            if (shift_en) begin
                y_out <= round_sat(64'(acc));
            end
        end
    end

endmodule

// File: rtl/rfnoc_block_pulse_shaping_filter.sv
// rtl/rfnoc_block_pulse_shaping_filter.sv - QPSK pulse-shaping FIR user core with ctrlport registers
// Ports: rfnoc_chdr_clk/rfnoc_chdr_rst (sync active-high); s_axis_* sc16 input stream;
//        m_axis_* filtered output stream (tlast preserved); s_ctrlport_req_*/resp_* register access.
// Registers: 0x00 user R/W, 0x08 num taps RO (bit31 = saturation build), 0x0C clear WO, 0x100+4k coef[k].
// Optional macro PULSE_SHAPING_SAT_EN: saturate instead of wrap on the output samples.
module rfnoc_block_pulse_shaping_filter
    import rfnoc_block_pulse_shaping_filter_pkg::*;
#(
    parameter int          NUM_TAPS         = 11,
    parameter int          COEF_W           = 16,
    parameter int          ITEM_W           = 32,
    parameter logic [31:0] REG_USER_DEFAULT = 32'h0
) (
    input  logic              rfnoc_chdr_clk,
    input  logic              rfnoc_chdr_rst,
    input  logic [ITEM_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [ITEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    input  logic              s_ctrlport_req_wr,
    input  logic              s_ctrlport_req_rd,
    input  logic [19:0]       s_ctrlport_req_addr,
    input  logic [31:0]       s_ctrlport_req_data,
    output logic              s_ctrlport_resp_ack,
    output logic [31:0]       s_ctrlport_resp_data
);

    logic [31:0]              user_reg;
    logic [31:0]              user_nxt;
    logic signed [COEF_W-1:0] coef     [NUM_TAPS];
    logic signed [COEF_W-1:0] coef_nxt [NUM_TAPS];
    logic [31:0]              rd_val;
    logic                     clear;
    logic                     s_hs;
    sample_t                  s_in;
    logic signed [15:0]       y_i;
    logic signed [15:0]       y_q;

    // Register file: write effects are computed first so a simultaneous read
    // returns the post-write value.
    always_comb begin
        user_nxt = user_reg;
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef_nxt[k] = coef[k];
        end
        clear = 1'b0;

        if (s_ctrlport_req_wr) begin
            if (s_ctrlport_req_addr == REG_USER_ADDR) begin
                user_nxt = s_ctrlport_req_data;
            end
            if (s_ctrlport_req_addr == REG_CLEAR_ADDR) begin
                clear = 1'b1;
            end
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (s_ctrlport_req_addr == reg_coef_addr(k)) begin
                    coef_nxt[k] = s_ctrlport_req_data[COEF_W-1:0];
                end
            end
        end

        rd_val = '0;
        if (s_ctrlport_req_addr == REG_USER_ADDR) begin
            rd_val = user_nxt;
        end
        if (s_ctrlport_req_addr == REG_NUM_TAPS_ADDR) begin
            rd_val = {SAT_EN, 31'(NUM_TAPS)};
        end
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (s_ctrlport_req_addr == reg_coef_addr(k)) begin
                rd_val = 32'(coef_nxt[k]);
            end
        end
    end

    always_ff @(posedge rfnoc_chdr_clk) begin
        if (rfnoc_chdr_rst) begin
            user_reg             <= REG_USER_DEFAULT;
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef[k] <= COEF_W'(default_coef(k));
            end
            s_ctrlport_resp_ack  <= 1'b0;
            s_ctrlport_resp_data <= '0;
        end else begin
            user_reg             <= user_nxt;
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef[k] <= coef_nxt[k];
            end
            s_ctrlport_resp_ack  <= s_ctrlport_req_wr | s_ctrlport_req_rd;
            s_ctrlport_resp_data <= s_ctrlport_req_rd ? rd_val : 32'h0;
        end
    end

    // Single output register stage: accept whenever that stage is empty or draining.
    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign s_in          = s_axis_tdata;

    always_ff @(posedge rfnoc_chdr_clk) begin
        if (rfnoc_chdr_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (s_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    psf_fir_mac #(
        .NUM_TAPS (NUM_TAPS),
        .COEF_W   (COEF_W)
    ) u_mac_i (
        .clk      (rfnoc_chdr_clk),
        .rst      (rfnoc_chdr_rst),
        .shift_en (s_hs),
        .clear    (clear),
        .x_in     (s_in.i),
        .coefs    (coef),
        .y_out    (y_i)
    );

    psf_fir_mac #(
        .NUM_TAPS (NUM_TAPS),
        .COEF_W   (COEF_W)
    ) u_mac_q (
        .clk      (rfnoc_chdr_clk),
        .rst      (rfnoc_chdr_rst),
        .shift_en (s_hs),
        .clear    (clear),
        .x_in     (s_in.q),
        .coefs    (coef),
        .y_out    (y_q)
    );

    assign m_axis_tdata = {y_i, y_q};

endmodule

// File: tb/tb_rfnoc_block_pulse_shaping_filter.sv
// tb/tb_rfnoc_block_pulse_shaping_filter.sv - directed self-checking bench for the pulse-shaping FIR core
module tb_rfnoc_block_pulse_shaping_filter;

    localparam int          NT       = 11;
    localparam logic [31:0] USER_DEF = 32'hCAFE_0001;
    localparam int          LIMIT    = 4000;
`ifdef PULSE_SHAPING_SAT_EN
    localparam logic [31:0] NTAPS_EXP = 32'h8000_000B;
`else
    localparam logic [31:0] NTAPS_EXP = 32'h0000_000B;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic        req_wr;
    logic        req_rd;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic        resp_ack;
    logic [31:0] resp_data;

    always #5 clk = ~clk;

    rfnoc_block_pulse_shaping_filter #(
        .NUM_TAPS         (NT),
        .COEF_W           (16),
        .ITEM_W           (32),
        .REG_USER_DEFAULT (USER_DEF)
    ) dut (
        .rfnoc_chdr_clk       (clk),
        .rfnoc_chdr_rst       (rst),
        .s_axis_tdata         (s_data),
        .s_axis_tlast         (s_last),
        .s_axis_tvalid        (s_valid),
        .s_axis_tready        (s_ready),
        .m_axis_tdata         (m_data),
        .m_axis_tlast         (m_last),
        .m_axis_tvalid        (m_valid),
        .m_axis_tready        (m_ready),
        .s_ctrlport_req_wr    (req_wr),
        .s_ctrlport_req_rd    (req_rd),
        .s_ctrlport_req_addr  (req_addr),
        .s_ctrlport_req_data  (req_data),
        .s_ctrlport_resp_ack  (resp_ack),
        .s_ctrlport_resp_data (resp_data)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] stim [$];
    logic [31:0] expd [$];
    longint      mh_i [NT];
    longint      mh_q [NT];
    longint      mc   [NT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reg_access(input logic wr, input logic rd, input logic [19:0] a,
                              input logic [31:0] d, output logic [31:0] q);
        req_wr   = wr;
        req_rd   = rd;
        req_addr = a;
        req_data = d;
        @(posedge clk); #1;
        req_wr = 1'b0;
        req_rd = 1'b0;
        chk("resp_ack", {31'b0, resp_ack}, 32'h1);
        q = resp_data;
        @(posedge clk); #1;
        chk("resp_ack_one_cycle", {31'b0, resp_ack}, 32'h0);
    endtask

    task automatic set_coef(input int k, input logic signed [15:0] v);
        logic [31:0] q;
        reg_access(1'b1, 1'b0, 20'h00100 + 20'(4 * k), 32'(v), q);
        mc[k] = longint'(v);
    endtask

    task automatic do_clear();
        logic [31:0] q;
        reg_access(1'b1, 1'b0, 20'h0000C, 32'h1, q);
    endtask

    function automatic void model_clear();
        for (int k = 0; k < NT; k++) begin
            mh_i[k] = 0;
            mh_q[k] = 0;
        end
    endfunction

    function automatic logic [15:0] mround(input longint acc);
        longint r;
        r = (acc + 64'sd16384) >>> 15;
`ifdef PULSE_SHAPING_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    // Independent reference: y[n] = sum_k c[k] * x[n-k], per component.
    function automatic logic [31:0] model_push(input logic [31:0] s);
        longint ai;
        longint aq;
        for (int k = NT - 1; k > 0; k--) begin
            mh_i[k] = mh_i[k-1];
            mh_q[k] = mh_q[k-1];
        end
        mh_i[0] = longint'($signed(s[31:16]));
        mh_q[0] = longint'($signed(s[15:0]));
        ai = 0;
        aq = 0;
        for (int k = 0; k < NT; k++) begin
            ai += mc[k] * mh_i[k];
            aq += mc[k] * mh_q[k];
        end
        return {mround(ai), mround(aq)};
    endfunction

    task automatic drive(input int total, input int spp, input int stall);
        int i = 0;
        int cyc = 0;
        logic took;
        while (i < total && cyc < LIMIT) begin
            s_data = stim[i];
            s_last = ((i % spp) == (spp - 1));
            if (!s_valid) s_valid = (int'($urandom_range(99)) >= stall);
            @(negedge clk);
            took = s_valid && s_ready;
            @(posedge clk); #1;
            cyc++;
            if (took) begin
                i++;
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic monitor(input int total, input int spp, input int stall);
        int j = 0;
        int cyc = 0;
        while (j < total && cyc < LIMIT) begin
            m_ready = (int'($urandom_range(99)) >= stall);
            @(negedge clk);
            if (m_valid && m_ready) begin
                chk($sformatf("out_data[%0d]", j), m_data, expd[j]);
                chk($sformatf("out_last[%0d]", j), {31'b0, m_last},
                    {31'b0, ((j % spp) == (spp - 1))});
                j++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b0;
        chk("out_count", j, total);
        chk("no_extra_output", {31'b0, m_valid}, 32'h0);
    endtask

    task automatic run_stream(input int spp, input int stall);
        int total = stim.size();
        fork
            drive(total, spp, stall);
            monitor(total, spp, stall);
        join
        stim.delete();
        expd.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q;
        longint      v;
        logic [31:0] s;
        rst = 1'b1; s_data = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        req_wr = 1'b0; req_rd = 1'b0; req_addr = '0; req_data = '0;
        for (int k = 0; k < NT; k++) mc[k] = (k == 0) ? 32767 : 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_tvalid", {31'b0, m_valid}, 32'h0);
        chk("rst_tdata", m_data, 32'h0);
        chk("rst_tlast", {31'b0, m_last}, 32'h0);
        chk("rst_ack", {31'b0, resp_ack}, 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);

        reg_access(1'b0, 1'b1, 20'h00000, 32'h0, q);          chk("user_default", q, USER_DEF);
        reg_access(1'b1, 1'b0, 20'h00000, 32'hDEADBEEF, q);
        reg_access(1'b0, 1'b1, 20'h00000, 32'h0, q);          chk("user_rw", q, 32'hDEADBEEF);
        reg_access(0, 1, 20'h00008, 32'h0, q);                chk("num_taps", q, NTAPS_EXP);
        reg_access(1'b1, 1'b1, 20'h00000, 32'h12345678, q);   chk("wr_rd_same_cycle", q, 32'h12345678);
        reg_access(1'b1, 1'b0, 20'h00004, 32'hFFFFFFFF, q);
        reg_access(1'b0, 1'b1, 20'h00004, 32'h0, q);          chk("unmapped_rd", q, 32'h0);
        reg_access(1'b0, 1'b1, 20'h00100, 32'h0, q);          chk("coef0_default", q, 32'h00007FFF);
        reg_access(1'b0, 1'b1, 20'h00128, 32'h0, q);          chk("coef10_default", q, 32'h0);
        reg_access(1'b0, 1'b1, 20'h0012C, 32'h0, q);          chk("coef11_unmapped", q, 32'h0);
        reg_access(1'b1, 1'b0, 20'h00108, 32'h00008000, q);
        reg_access(1'b0, 1'b1, 20'h00108, 32'h0, q);          chk("coef_sign_ext", q, 32'hFFFF8000);
        set_coef(2, 16'sd0);

        // Pass-through: 64 samples of (1000, -1000).
        for (int n = 0; n < 64; n++) begin
            stim.push_back({16'd1000, 16'hFC18});
            expd.push_back({16'd1000, 16'hFC18});
        end
        run_stream(64, 0);

        // Impulse response with coef[k] = 1000*(k+1), after clearing the 1000s left in the line.
        for (int k = 0; k < NT; k++) set_coef(k, 16'(1000 * (k + 1)));
        do_clear();
        stim.push_back({16'h7FFF, 16'h7FFF});
        for (int n = 1; n < NT; n++) stim.push_back(32'h0);
        for (int k = 0; k < NT; k++) begin
            v = (longint'(32767) * 1000 * (k + 1) + 16384) / 32768;
            expd.push_back({v[15:0], v[15:0]});
        end
        run_stream(NT, 0);

        // Full-scale coefficients and inputs: saturation or wrap.
        for (int k = 0; k < NT; k++) set_coef(k, 16'sh7FFF);
        do_clear();
        for (int n = 0; n < NT; n++) begin
            stim.push_back({16'h7FFF, 16'h0000});
            v = (longint'(n + 1) * 32767 * 32767 + 16384) >>> 15;
`ifdef PULSE_SHAPING_SAT_EN
            if (v > 32767) v = 32767;
`endif
            expd.push_back({v[15:0], 16'h0000});
        end
        run_stream(NT, 0);

        // Random coefficients and data, 25% stalls both sides, 4 packets of 64.
        for (int k = 0; k < NT; k++) set_coef(k, 16'(int'($urandom_range(16383)) - 8192));
        do_clear();
        model_clear();
        for (int n = 0; n < 256; n++) begin
            s = $urandom;
            stim.push_back(s);
            expd.push_back(model_push(s));
        end
        run_stream(64, 25);

        // Reset in the middle of a packet.
        m_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b0;
        chk("midrst_tvalid", {31'b0, m_valid}, 32'h0);
        reg_access(1'b0, 1'b1, 20'h00000, 32'h0, q);          chk("midrst_user", q, USER_DEF);
        reg_access(1'b0, 1'b1, 20'h00100, 32'h0, q);          chk("midrst_coef0", q, 32'h00007FFF);
        reg_access(1'b0, 1'b1, 20'h0010C, 32'h0, q);          chk("midrst_coef3", q, 32'h0);
        for (int k = 0; k < NT; k++) mc[k] = (k == 0) ? 32767 : 0;
        set_coef(0, 16'sd16384);
        set_coef(1, -16'sd8192);
        set_coef(2, 16'sd4096);
        model_clear();
        for (int n = 0; n < 8; n++) begin
            s = $urandom;
            stim.push_back(s);
            expd.push_back(model_push(s));
        end
        run_stream(8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
